// File: rtl/and2_stim_ctrl.sv
// and2_stim_ctrl: sweeps all four {a,b} vectors into a 2-input AND stage and checks y.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, sampled only while idle
//   a, b                registered stimulus toward the AND stage
//   y                   AND stage response, sampled at the end of each check cycle
//   busy, done          run in progress / one-cycle end-of-run pulse
//   pass_cnt, err_cnt   saturating match / mismatch counts for the last run
//   err_vec             bit i set when vector {a,b}=i mismatched during the last run
module and2_stim_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       err_vec
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(PASSES + 1);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       ab_q, ab_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       err_vec_q, err_vec_d;
    logic             last;

    assign last = (idx_q == 2'd3) && (pcnt_q == PW'(PASSES - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ab_d       = ab_q;
        settle_d   = settle_q;
        pcnt_d     = pcnt_q;
        pass_cnt_d = pass_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_vec_d  = err_vec_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = APPLY;
                idx_d      = 2'd0;
                ab_d       = 2'd0;
                settle_d   = SW'(SETTLE_CYCLES);
                pcnt_d     = '0;
                pass_cnt_d = '0;
                err_cnt_d  = '0;
                err_vec_d  = '0;
            end
            APPLY: begin
                // counter holds the cycles left in APPLY including the current one
                state_d  = (settle_q == SW'(1)) ? CHECK : APPLY;
                settle_d = settle_q - SW'(1);
            end
            CHECK: begin
                if (y == (idx_q[1] & idx_q[0]))
                    pass_cnt_d = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
                else begin
                    err_cnt_d        = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                    err_vec_d[idx_q] = 1'b1;
                end
                if (last) begin
                    state_d = DONE;
                    ab_d    = 2'd0;
                end else begin
                    state_d  = APPLY;
                    idx_d    = idx_q + 2'd1;
                    ab_d     = idx_q + 2'd1;
                    settle_d = SW'(SETTLE_CYCLES);
                    pcnt_d   = (idx_q == 2'd3) ? pcnt_q + PW'(1) : pcnt_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ab_q       <= '0;
            settle_q   <= '0;
            pcnt_q     <= '0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_vec_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ab_q       <= ab_d;
            settle_q   <= settle_d;
            pcnt_q     <= pcnt_d;
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_vec_q  <= err_vec_d;
        end
    end

    assign a        = ab_q[1];
    assign b        = ab_q[0];
    assign busy     = (state_q == APPLY) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass_cnt = pass_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign err_vec  = err_vec_q;
endmodule
